// File: rtl/png_chunk_ctrl_if.sv
// Handshake/bus bundle around the PNG chunk sequencer: producer request,
// upstream data words, downstream output words and the crc32 core link.
// The slave modport is the controller's view; master is its environment.
interface png_chunk_ctrl_if;
  logic        start_i;
  logic [31:0] len_i;
  logic [31:0] typ_i;
  logic        dat_val_i;
  logic [31:0] dat_i;
  logic        dat_rdy_o;
  logic        out_val_o;
  logic [31:0] out_dat_o;
  logic        out_lst_o;
  logic        out_rdy_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        crc_start_o;
  logic        crc_val_o;
  logic [31:0] crc_dat_o;
  logic        crc_lst_o;
  logic        crc_val_i;
  logic        crc_done_i;
  logic [31:0] crc_dat_i;

  modport slave (
    input  start_i, len_i, typ_i, dat_val_i, dat_i, out_rdy_i,
    input  crc_val_i, crc_done_i, crc_dat_i,
    output dat_rdy_o, out_val_o, out_dat_o, out_lst_o, busy_o, done_o, err_o,
    output crc_start_o, crc_val_o, crc_dat_o, crc_lst_o
  );

  modport master (
    output start_i, len_i, typ_i, dat_val_i, dat_i, out_rdy_i,
    output crc_val_i, crc_done_i, crc_dat_i,
    input  dat_rdy_o, out_val_o, out_dat_o, out_lst_o, busy_o, done_o, err_o,
    input  crc_start_o, crc_val_o, crc_dat_o, crc_lst_o
  );
endinterface

// File: rtl/png_chunk_ctrl.sv
// PNG chunk sequencer: emits LENGTH, TYPE, DATA..., CRC as a 32-bit word
// stream and paces TYPE/DATA into the shared crc32 core.
module png_chunk_ctrl #(
  parameter int unsigned CNT_WD = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  png_chunk_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {StIdle, StHdr, StTyp, StDat, StWcrc, StCrc} state_e;

  localparam logic [CNT_WD-1:0] CntOne = CNT_WD'(1);

  state_e              state_q, state_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic [31:0]         typ_q, typ_d;
  logic                ob_val_q, ob_val_d;
  logic [31:0]         ob_dat_q, ob_dat_d;
  logic                ob_lst_q, ob_lst_d;
  logic                crc_start_q, crc_start_d;
  logic                crc_val_q, crc_val_d;
  logic [31:0]         crc_dat_q, crc_dat_d;
  logic                crc_lst_q, crc_lst_d;
  logic                crc_free_q, crc_free_d;
  logic [31:0]         crc_q, crc_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                ob_free;
  logic                crc_rdy_in;
  logic                crc_free;
  logic                dat_rdy;
  logic                len_bad;
  logic                commit;
  logic [31:0]         commit_w;
  logic                commit_lst;

  // Handshake qualifiers; core readiness only counts while a payload word is pending.
  always_comb begin
    ob_free    = !ob_val_q || bus.out_rdy_i;
    crc_rdy_in = bus.crc_val_i && !bus.crc_done_i && (state_q == StTyp || state_q == StDat);
    crc_free   = crc_free_q || crc_rdy_in;
    dat_rdy    = (state_q == StDat) && bus.dat_val_i && ob_free && crc_free;
    len_bad    = (|bus.len_i[1:0]) || (|bus.len_i[31:CNT_WD+2]);
  end

  // Next-state logic for the FSM, output buffer and core interface.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    typ_d       = typ_q;
    ob_val_d    = ob_val_q && !bus.out_rdy_i;
    ob_lst_d    = ob_lst_q && !(ob_val_q && bus.out_rdy_i);
    ob_dat_d    = ob_dat_q;
    crc_start_d = 1'b0;
    crc_val_d   = 1'b0;
    crc_dat_d   = crc_dat_q;
    crc_lst_d   = crc_lst_q;
    crc_free_d  = crc_free || crc_start_q;
    crc_d       = crc_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    commit      = 1'b0;
    commit_w    = '0;
    commit_lst  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            typ_d       = bus.typ_i;
            cnt_d       = bus.len_i[CNT_WD+1:2];
            ob_val_d    = 1'b1;
            ob_dat_d    = bus.len_i;
            ob_lst_d    = 1'b0;
            crc_start_d = 1'b1;
            state_d     = StHdr;
          end
        end
      end
      StHdr: begin
        if (crc_free) state_d = StTyp;
      end
      StTyp: begin
        if (ob_free && crc_free) begin
          commit     = 1'b1;
          commit_w   = typ_q;
          commit_lst = (cnt_q == '0);
          state_d    = commit_lst ? StWcrc : StDat;
        end
      end
      StDat: begin
        if (dat_rdy) begin
          commit     = 1'b1;
          commit_w   = bus.dat_i;
          commit_lst = (cnt_q == CntOne);
          cnt_d      = cnt_q - CntOne;
          if (commit_lst) state_d = StWcrc;
        end
      end
      StWcrc: begin
        if (bus.crc_done_i) begin
          crc_d   = bus.crc_dat_i;
          state_d = StCrc;
        end
      end
      StCrc: begin
        // ob_lst_q marks that the CRC word already sits in the output buffer.
        if (ob_lst_q) begin
          if (ob_val_q && bus.out_rdy_i) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else if (ob_free) begin
          ob_val_d = 1'b1;
          ob_dat_d = crc_q;
          ob_lst_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      ob_val_d   = 1'b1;
      ob_dat_d   = commit_w;
      ob_lst_d   = 1'b0;
      crc_dat_d  = commit_w;
      crc_val_d  = 1'b1;
      crc_lst_d  = commit_lst;
      crc_free_d = 1'b0;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      typ_q       <= '0;
      ob_val_q    <= 1'b0;
      ob_dat_q    <= '0;
      ob_lst_q    <= 1'b0;
      crc_start_q <= 1'b0;
      crc_val_q   <= 1'b0;
      crc_dat_q   <= '0;
      crc_lst_q   <= 1'b0;
      crc_free_q  <= 1'b0;
      crc_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      typ_q       <= typ_d;
      ob_val_q    <= ob_val_d;
      ob_dat_q    <= ob_dat_d;
      ob_lst_q    <= ob_lst_d;
      crc_start_q <= crc_start_d;
      crc_val_q   <= crc_val_d;
      crc_dat_q   <= crc_dat_d;
      crc_lst_q   <= crc_lst_d;
      crc_free_q  <= crc_free_d;
      crc_q       <= crc_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.dat_rdy_o   = dat_rdy;
  assign bus.out_val_o   = ob_val_q;
  assign bus.out_dat_o   = ob_dat_q;
  assign bus.out_lst_o   = ob_lst_q;
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.crc_start_o = crc_start_q;
  assign bus.crc_val_o   = crc_val_q;
  assign bus.crc_dat_o   = crc_dat_q;
  assign bus.crc_lst_o   = crc_lst_q;

endmodule

// File: tb/tb_png_chunk_ctrl.sv
// Directed bench for png_chunk_ctrl with a behavioural crc32 core model.
module tb_png_chunk_ctrl;

  logic clk;
  logic rstn;

  png_chunk_ctrl_if bus ();

  png_chunk_ctrl #(.CNT_WD(14)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] dq[$];
  logic [31:0] mon_w[$];
  logic        mon_l[$];
  int          n_done;
  int          n_err;
  int          n_viol;
  int          commit_cyc[$];
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // PNG CRC-32 step over one big-endian word.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 3; b >= 0; b--) begin
      r = r ^ {24'h0, w[8*b +: 8]};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] chunk_crc(input logic [31:0] typ, input int nw);
    logic [31:0] c;
    c = crc_upd(32'hFFFFFFFF, typ);
    for (int i = 0; i < nw; i++) c = crc_upd(c, dq[i]);
    return ~c;
  endfunction

  // crc32 core model: word seen at E+1, ready (or done) seen by the DUT at E+5.
  logic [31:0] core_acc;
  int          core_cd;
  logic        core_lst;
  always @(posedge clk) begin
    if (!rstn) begin
      core_acc       <= '0;
      core_cd        <= 0;
      core_lst       <= 1'b0;
      bus.crc_val_i  <= 1'b0;
      bus.crc_done_i <= 1'b0;
      bus.crc_dat_i  <= '0;
    end else begin
      bus.crc_val_i  <= 1'b0;
      bus.crc_done_i <= 1'b0;
      if (bus.crc_start_o) core_acc <= 32'hFFFFFFFF;
      if (bus.crc_val_o) begin
        core_acc <= crc_upd(core_acc, bus.crc_dat_o);
        core_cd  <= 3;
        core_lst <= bus.crc_lst_o;
      end else if (core_cd != 0) begin
        core_cd <= core_cd - 1;
        if (core_cd == 1) begin
          bus.crc_val_i <= 1'b1;
          if (core_lst) begin
            bus.crc_done_i <= 1'b1;
            bus.crc_dat_i  <= ~core_acc;
          end
        end
      end
    end
  end

  // Output/handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.out_val_o && bus.out_rdy_i) begin
        mon_w.push_back(bus.out_dat_o);
        mon_l.push_back(bus.out_lst_o);
      end
      if (bus.crc_val_o) commit_cyc.push_back(int'(cyc));
      if (bus.done_o) n_done++;
      if (bus.err_o) n_err++;
      if (bus.dat_rdy_o && bus.out_val_o && !bus.out_rdy_i) n_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_w.delete();
    mon_l.delete();
    commit_cyc.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  // Drives one chunk; returns at the done_o cycle, or after rst_after commits if nonzero.
  task automatic run_chunk(input logic [31:0] len, input logic [31:0] typ, input int nw,
                           input bit rnd, input int restart_at, input int rst_after,
                           output bit got_done);
    int  k;
    int  ncommit;
    bit  adv;
    got_done = 1'b0;
    k        = 0;
    ncommit  = 0;
    clear_mon();
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.len_i     = len;
    bus.typ_i     = typ;
    bus.dat_val_i = (nw > 0);
    bus.dat_i     = (nw > 0) ? dq[0] : 32'h0;
    bus.out_rdy_i = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      adv = bus.dat_rdy_o;
      if (bus.crc_val_o) ncommit++;
      if (bus.done_o) begin
        got_done = 1'b1;
        break;
      end
      if (rst_after > 0 && ncommit >= rst_after) break;
      @(posedge clk); #1;
      bus.start_i = (c == restart_at);
      if (c == restart_at) begin
        bus.len_i = 32'd4;
        bus.typ_i = 32'hDEADBEEF;
      end
      if (adv) k++;
      bus.dat_val_i = (k < nw);
      bus.dat_i     = (k < nw) ? dq[k] : 32'h0;
      bus.out_rdy_i = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
    #1;
    if (rst_after == 0) check("chunk_done_seen", {31'h0, got_done}, 32'd1);
  endtask

  task automatic check_chunk(input string tag, input logic [31:0] len, input logic [31:0] typ,
                             input int nw, input logic [31:0] exp_crc);
    logic [31:0] exp_w[$];
    logic [31:0] got;
    logic        got_l;
    exp_w.push_back(len);
    exp_w.push_back(typ);
    for (int i = 0; i < nw; i++) exp_w.push_back(dq[i]);
    exp_w.push_back(exp_crc);
    check({tag, "_nwords"}, mon_w.size(), nw + 3);
    for (int i = 0; i < nw + 3; i++) begin
      got   = (i < mon_w.size()) ? mon_w[i] : 32'hxxxxxxxx;
      got_l = (i < mon_l.size()) ? mon_l[i] : 1'bx;
      check($sformatf("%s_w%0d", tag, i), got, exp_w[i]);
      check($sformatf("%s_lst%0d", tag, i), {31'h0, got_l}, {31'h0, (i == nw + 2)});
    end
    check({tag, "_done_cnt"}, n_done, 1);
  endtask

  bit got;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn          = 1'b0;
    bus.start_i   = 1'b0;
    bus.len_i     = '0;
    bus.typ_i     = '0;
    bus.dat_val_i = 1'b0;
    bus.dat_i     = '0;
    bus.out_rdy_i = 1'b1;
    n_viol        = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {21'h0, bus.busy_o, bus.out_val_o, bus.out_lst_o, bus.done_o, bus.err_o,
                      bus.crc_start_o, bus.crc_val_o, bus.crc_lst_o, bus.dat_rdy_o, 2'b0}, 32'h0);
    check("rst_out_dat", bus.out_dat_o, 32'h0);
    check("rst_crc_dat", bus.crc_dat_o, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // IEND, no backpressure
    dq.delete();
    run_chunk(32'd0, 32'h49454E44, 0, 1'b0, -1, 0, got);
    check_chunk("iend", 32'd0, 32'h49454E44, 0, 32'hAE426082);

    // 8-byte IDAT, commit spacing
    dq = '{32'h78DA6364, 32'h00000000};
    run_chunk(32'd8, 32'h49444154, 2, 1'b0, -1, 0, got);
    check_chunk("idat", 32'd8, 32'h49444154, 2, chunk_crc(32'h49444154, 2));
    check("idat_ncommit", commit_cyc.size(), 3);
    check("idat_gap0", (commit_cyc.size() >= 2) ? commit_cyc[1] - commit_cyc[0] : 0, 5);
    check("idat_gap1", (commit_cyc.size() >= 3) ? commit_cyc[2] - commit_cyc[1] : 0, 5);

    // Same chunk under random backpressure
    run_chunk(32'd8, 32'h49444154, 2, 1'b1, -1, 0, got);
    check_chunk("idat_bp", 32'd8, 32'h49444154, 2, chunk_crc(32'h49444154, 2));
    check("bp_rdy_violations", n_viol, 0);

    // Rejected requests
    clear_mon();
    @(posedge clk); #1;
    bus.out_rdy_i = 1'b1;
    bus.start_i   = 1'b1;
    bus.len_i     = 32'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("rej5_err", {31'h0, bus.err_o}, 32'd1);
    check("rej5_busy", {31'h0, bus.busy_o}, 32'd0);
    @(negedge clk);
    check("rej5_err_pulse", {31'h0, bus.err_o}, 32'd0);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.len_i   = 32'h0001_0000;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("rejbig_err", {31'h0, bus.err_o}, 32'd1);
    check("rejbig_busy", {31'h0, bus.busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("rej_no_output", mon_w.size(), 0);
    check("rej_err_cnt", n_err, 2);

    // start_i re-pulsed while busy
    run_chunk(32'd8, 32'h49444154, 2, 1'b0, 4, 0, got);
    check_chunk("restart", 32'd8, 32'h49444154, 2, chunk_crc(32'h49444154, 2));
    check("restart_no_err", n_err, 0);

    // Back-to-back: second start the cycle after done_o
    run_chunk(32'd8, 32'h49444154, 2, 1'b0, -1, 0, got);
    check_chunk("b2b_a", 32'd8, 32'h49444154, 2, chunk_crc(32'h49444154, 2));
    dq.delete();
    run_chunk(32'd0, 32'h49454E44, 0, 1'b0, -1, 0, got);
    check_chunk("b2b_b", 32'd0, 32'h49454E44, 0, 32'hAE426082);

    // Reset after the 2nd data commit
    dq = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    run_chunk(32'd12, 32'h49444154, 3, 1'b0, -1, 3, got);
    @(posedge clk); #1;
    rstn          = 1'b0;
    bus.dat_val_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_ctl", {21'h0, bus.busy_o, bus.out_val_o, bus.out_lst_o, bus.done_o, bus.err_o,
                       bus.crc_start_o, bus.crc_val_o, bus.crc_lst_o, bus.dat_rdy_o, 2'b0}, 32'h0);
    check("mrst_out_dat", bus.out_dat_o, 32'h0);
    check("mrst_crc_dat", bus.crc_dat_o, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    dq.delete();
    run_chunk(32'd0, 32'h49454E44, 0, 1'b0, -1, 0, got);
    check_chunk("post_rst_iend", 32'd0, 32'h49454E44, 0, 32'hAE426082);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
